// File: rtl/vent_fan_if.sv
// Room fan link: ventilation request and demand level in, fan drive and status out.
interface vent_fan_if;
    logic       state_vintilation;
    logic [3:0] counter;
    logic       fan_pwm;
    logic       fan_on;
    logic [3:0] speed;
    logic       ramp_busy;
    logic [1:0] fsm_state;

    modport master (
        output state_vintilation, counter,
        input  fan_pwm, fan_on, speed, ramp_busy, fsm_state
    );

    modport slave (
        input  state_vintilation, counter,
        output fan_pwm, fan_on, speed, ramp_busy, fsm_state
    );
endinterface

// File: rtl/vent_fan_driver.sv
// Room fan driver: soft-ramped duty level, PWM output and a minimum run time
// so short ventilation requests never cycle the motor.
module vent_fan_driver #(
    parameter int unsigned RAMP_DIV = 8,
    parameter int unsigned MIN_ON   = 32,
    parameter int unsigned MIN_DUTY = 4
) (
    input  logic      clk,
    input  logic      rst,
    vent_fan_if.slave bus
);
    localparam int unsigned PW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned TW = 8;
    localparam logic [PW-1:0] PRE_LAST   = PW'(RAMP_DIV - 1);
    localparam logic [3:0]    DUTY_FLOOR = 4'(MIN_DUTY);
    localparam logic [TW-1:0] TMR_LOAD   = TW'(MIN_ON);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    speed;
    logic [3:0]    pwm_cnt;
    logic [PW-1:0] prescaler;
    logic [TW-1:0] min_timer;
    logic          fan_on;
    logic          fan_pwm;
    logic          ramp_busy;

    logic          hold_c;
    logic [3:0]    target_c;
    logic          step_c;

    // Demand is live every cycle; the run timer keeps it alive after the request drops.
    always_comb begin
        hold_c   = bus.state_vintilation | (min_timer != '0);
        target_c = 4'd0;
        if (hold_c) begin
            target_c = (bus.counter > DUTY_FLOOR) ? bus.counter : DUTY_FLOOR;
        end
        step_c   = (prescaler == PRE_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_OFF;
            speed     <= 4'd0;
            pwm_cnt   <= 4'd0;
            prescaler <= '0;
            min_timer <= '0;
            fan_on    <= 1'b0;
            fan_pwm   <= 1'b0;
            ramp_busy <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            fan_pwm <= (pwm_cnt < speed);
            if (min_timer != '0) begin
                min_timer <= min_timer - TW'(1);
            end

            case (state)
                ST_OFF: begin
                    speed <= 4'd0;
                    if (bus.state_vintilation) begin
                        state     <= ST_RAMP;
                        fan_on    <= 1'b1;
                        ramp_busy <= 1'b1;
                        min_timer <= TMR_LOAD;
                        prescaler <= '0;
                    end
                end
                ST_RAMP: begin
                    if ((speed == target_c) && (target_c != 4'd0)) begin
                        state     <= ST_RUN;
                        ramp_busy <= 1'b0;
                    end else if ((speed == 4'd0) && (target_c == 4'd0)) begin
                        state     <= ST_OFF;
                        fan_on    <= 1'b0;
                        ramp_busy <= 1'b0;
                    end else if (step_c) begin
                        // Direction is re-evaluated at each step so target changes re-aim the ramp.
                        prescaler <= '0;
                        if (speed < target_c) begin
                            speed <= speed + 4'd1;
                        end else if (speed > target_c) begin
                            speed <= speed - 4'd1;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                ST_RUN: begin
                    if (target_c != speed) begin
                        state     <= ST_RAMP;
                        ramp_busy <= 1'b1;
                        prescaler <= '0;
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    speed     <= 4'd0;
                    fan_on    <= 1'b0;
                    ramp_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fsm_state = state;
    assign bus.speed     = speed;
    assign bus.fan_on    = fan_on;
    assign bus.fan_pwm   = fan_pwm;
    assign bus.ramp_busy = ramp_busy;
endmodule

// File: tb/tb_vent_fan_driver.sv
// Bench for vent_fan_driver: reset/ramp vector table, directed corner sequences,
// and randomized traffic against an edge-indexed reference model.
module tb_vent_fan_driver;
    localparam int RAMP_DIV = 8;
    localparam int MIN_ON   = 32;
    localparam int MIN_DUTY = 4;

    logic clk;
    logic rst;
    vent_fan_if bus ();

    vent_fan_driver #(.RAMP_DIV(RAMP_DIV), .MIN_ON(MIN_ON), .MIN_DUTY(MIN_DUTY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timing expressed as distances in edges from remembered events.
    int  e_now       = 0;
    int  entry_edge  = -100000;
    int  ramp_edge   = 0;
    int  reset_edge  = 0;
    int  m_mode      = 0;
    int  m_speed     = 0;
    int  m_pwm       = 0;
    bit  m_valid     = 1'b0;

    always @(posedge clk) begin
        int tgt;
        int dmd;
        bit hold;
        int new_pwm;
        e_now++;
        if (rst === 1'b0) begin
            m_mode     = 0;
            m_speed    = 0;
            m_pwm      = 0;
            reset_edge = e_now;
            entry_edge = -100000;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            hold = bus.state_vintilation ||
                   ((e_now - entry_edge >= 1) && (e_now - entry_edge <= MIN_ON));
            dmd  = int'(bus.counter);
            tgt  = hold ? ((dmd > MIN_DUTY) ? dmd : MIN_DUTY) : 0;
            new_pwm = (((e_now - reset_edge - 1) % 16) < m_speed) ? 1 : 0;
            if (m_mode == 0) begin
                if (bus.state_vintilation) begin
                    m_mode     = 1;
                    entry_edge = e_now;
                    ramp_edge  = e_now;
                end
            end else if (m_mode == 1) begin
                if (m_speed == tgt && tgt != 0) m_mode = 2;
                else if (m_speed == 0 && tgt == 0) m_mode = 0;
                else if ((e_now - ramp_edge) % RAMP_DIV == 0)
                    m_speed = m_speed + ((tgt > m_speed) ? 1 : (tgt < m_speed) ? -1 : 0);
            end else begin
                if (tgt != m_speed) begin
                    m_mode    = 1;
                    ramp_edge = e_now;
                end
            end
            m_pwm = new_pwm;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (int'(bus.fsm_state) !== m_mode || int'(bus.speed) !== m_speed ||
                int'(bus.fan_pwm) !== m_pwm || int'(bus.fan_on) !== int'(m_mode != 0) ||
                int'(bus.ramp_busy) !== int'(m_mode == 1)) begin
                errors++;
                $display("FAIL model: got st=%0d spd=%0d pwm=%0d on=%0d busy=%0d expected st=%0d spd=%0d pwm=%0d at %0t",
                         bus.fsm_state, bus.speed, bus.fan_pwm, bus.fan_on, bus.ramp_busy,
                         m_mode, m_speed, m_pwm, $time);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.state_vintilation = 1'b0;
        bus.counter = 4'd0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic wait_speed(input int v, input int budget, input string name);
        int n = 0;
        while (int'(bus.speed) != v && n < budget) begin
            cyc();
            n++;
        end
        check(name, int'(bus.speed), v);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(bus.fsm_state) != s && n < budget) begin
            cyc();
            n++;
        end
        check(name, int'(bus.fsm_state), s);
    endtask

    typedef struct {
        logic       rst;
        logic       sv;
        logic [3:0] cnt;
        int         st;
        int         spd;
        int         on;
        int         pwm;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int on_cnt;
        int max_spd;
        int gap;
        int prev;
        int first_move;
        bit saw_off;

        for (int i = 0; i < 3; i++) vecs[i] = '{1'b0, 1'b1, 4'd9, 0, 0, 0, 0};
        for (int i = 3; i < 11; i++) vecs[i] = '{1'b1, 1'b1, 4'd9, 1, 0, 1, 0};
        vecs[11] = '{1'b1, 1'b1, 4'd9, 1, 1, 1, 0};

        rst = 1'b0;
        bus.state_vintilation = 1'b0;
        bus.counter = 4'd0;
        @(negedge clk);

        // Reset under active request, then release into the first ramp step.
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            bus.state_vintilation = vecs[i].sv;
            bus.counter = vecs[i].cnt;
            cyc();
            check($sformatf("vec%0d_state", i), int'(bus.fsm_state), vecs[i].st);
            check($sformatf("vec%0d_speed", i), int'(bus.speed), vecs[i].spd);
            check($sformatf("vec%0d_fan_on", i), int'(bus.fan_on), vecs[i].on);
            check($sformatf("vec%0d_pwm", i), int'(bus.fan_pwm), vecs[i].pwm);
            check($sformatf("vec%0d_busy", i), int'(bus.ramp_busy), int'(vecs[i].st == 1));
        end

        // Ramp up to 10 from OFF.
        do_reset();
        bus.state_vintilation = 1'b1;
        bus.counter = 4'd10;
        cyc();
        check("ramp_entry_state", int'(bus.fsm_state), 1);
        for (int i = 1; i <= 80; i++) begin
            cyc();
            if (i == 8)  check("ramp_speed_k8", int'(bus.speed), 1);
            if (i == 79) check("ramp_speed_k79", int'(bus.speed), 9);
            if (i == 80) check("ramp_speed_k80", int'(bus.speed), 10);
        end
        check("ramp_state_k80", int'(bus.fsm_state), 1);
        cyc();
        check("ramp_run_k81", int'(bus.fsm_state), 2);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            on_cnt += int'(bus.fan_pwm);
        end
        check("pwm_high_of_16", on_cnt, 10);

        // Minimum duty floor.
        bus.counter = 4'd1;
        wait_state(1, 4, "min_duty_leave_run");
        wait_state(2, 200, "min_duty_run");
        check("min_duty_speed", int'(bus.speed), MIN_DUTY);
        bus.counter = 4'd0;
        for (int i = 0; i < 20; i++) cyc();
        check("min_duty_hold_speed", int'(bus.speed), MIN_DUTY);
        check("min_duty_hold_state", int'(bus.fsm_state), 2);

        // One-cycle request: timer keeps the fan on, then ramps down to OFF.
        do_reset();
        bus.state_vintilation = 1'b1;
        cyc();
        bus.state_vintilation = 1'b0;
        on_cnt = 0;
        max_spd = 0;
        for (int i = 0; i < 300 && int'(bus.fsm_state) != 0; i++) begin
            cyc();
            on_cnt += int'(bus.fan_on);
            if (int'(bus.speed) > max_spd) max_spd = int'(bus.speed);
        end
        check("min_on_cycles", on_cnt, 64);
        check("min_on_max_speed", max_spd, MIN_DUTY);
        check("min_on_end_fan_on", int'(bus.fan_on), 0);
        check("min_on_end_speed", int'(bus.speed), 0);

        // Ramp-down step spacing and reversal without passing through OFF.
        do_reset();
        bus.state_vintilation = 1'b1;
        bus.counter = 4'd12;
        wait_state(2, 200, "rev_run");
        check("rev_run_speed", int'(bus.speed), 12);
        bus.state_vintilation = 1'b0;
        wait_speed(11, 40, "rev_first_down");
        gap = 0;
        while (int'(bus.speed) == 11 && gap < 40) begin
            cyc();
            gap++;
        end
        check("rev_step_gap", gap, RAMP_DIV);
        check("rev_step_to10", int'(bus.speed), 10);
        wait_speed(7, 60, "rev_reach7");
        bus.state_vintilation = 1'b1;
        bus.counter = 4'd9;
        prev = 7;
        first_move = -1;
        saw_off = 1'b0;
        for (int i = 0; i < 100 && int'(bus.fsm_state) != 2; i++) begin
            cyc();
            if (int'(bus.fsm_state) == 0) saw_off = 1'b1;
            if (first_move < 0 && int'(bus.speed) != prev) first_move = int'(bus.speed);
        end
        check("rev_first_move", first_move, 8);
        check("rev_no_off", int'(saw_off), 0);
        check("rev_final_state", int'(bus.fsm_state), 2);
        check("rev_final_speed", int'(bus.speed), 9);

        // Reset in the middle of a ramp.
        do_reset();
        bus.state_vintilation = 1'b1;
        bus.counter = 4'd15;
        wait_speed(6, 80, "mid_reach6");
        check("mid_ramp_state", int'(bus.fsm_state), 1);
        rst = 1'b0;
        cyc();
        check("mid_rst_speed", int'(bus.speed), 0);
        check("mid_rst_fan_on", int'(bus.fan_on), 0);
        check("mid_rst_pwm", int'(bus.fan_pwm), 0);
        check("mid_rst_state", int'(bus.fsm_state), 0);
        rst = 1'b1;

        // Randomized traffic; the model checker compares every cycle.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.state_vintilation = ~bus.state_vintilation;
            if ($urandom_range(0, 29) == 0) bus.counter = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 799) != 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vent_fan_driver.md
Name: vent_fan_driver

Overview:
- Downstream consumer of the ventilation block. Takes its ventilation request (state_vintilation) and 4-bit demand level (counter), and drives the room fan.
- Produces a soft-ramped duty level, a PWM output and a fan enable.
- Enforces a minimum fan run time so short sensor glitches do not cycle the motor.

Parameters:
- RAMP_DIV, 8, clock cycles per one-step change of speed (>=2)
- MIN_ON, 32, minimum cycles fan_on stays high after leaving OFF (>=1, fits 8 bits)
- MIN_DUTY, 4, lowest nonzero duty while running (1..15)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (rst=0 at a rising edge resets)
- state_vintilation  input  1  ventilation requested by upstream block
- counter  input  4  demand level from upstream block, 0..15
- fan_pwm  output  1  PWM drive, duty = speed/16
- fan_on  output  1  fan power enable
- speed  output  4  current applied duty level
- ramp_busy  output  1  high while in RAMP state
- fsm_state  output  2  OFF=0, RAMP=1, RUN=2

Behaviour:
- Reset (rst=0 at edge): fsm_state=OFF, speed=0, fan_on=0, fan_pwm=0, ramp_busy=0, pwm_cnt=0, prescaler=0, min timer=0. Applies mid-ramp or mid-run the same way, with no ramp-down.
- min timer: loaded with MIN_ON on the edge leaving OFF. Decrements by 1 each cycle while nonzero and holds at 0.
- hold = state_vintilation | (min timer != 0).
- target (combinational) = hold ? max(counter, MIN_DUTY) : 0. Inputs are sampled every cycle, not latched.
- pwm_cnt: free-running 4-bit counter that wraps 15->0. fan_pwm = (pwm_cnt < speed), registered. speed=0 gives a constant 0; speed=15 gives 15 of 16 cycles high.
- Prescaler:
  - Cleared on every entry into RAMP.
  - Counts 0..RAMP_DIV-1 while in RAMP.
  - A "step" occurs on the edge where prescaler==RAMP_DIV-1 (then it wraps to 0).
  - On a step, speed moves 1 toward the current target (+1 if below, -1 if above, no change if equal).
  - speed never wraps: it is bounded 0..15.
- FSM:
  - OFF: speed=0, fan_on=0. If state_vintilation=1 -> RAMP, fan_on<=1, load min timer. Otherwise stay.
  - RAMP:
    - If speed==target and target!=0 -> RUN.
    - If speed==0 and target==0 -> OFF, fan_on<=0.
    - Otherwise step per prescaler.
    - Target changes mid-ramp re-aim the next step; direction is evaluated at each step.
  - RUN: speed held. If target!=speed -> RAMP (prescaler cleared).
- Latency:
  - The RAMP->RUN transition occurs on the edge after the final step.
  - From an OFF entry at edge k with a constant target T, speed reaches T at edge k+8*T (RAMP_DIV=8), and fsm_state=RUN at edge k+8*T+1.
- Simultaneous events:
  - If state_vintilation falls while the min timer is nonzero, target stays MIN_DUTY or counter until the timer expires. Only then does ramp-down begin.
  - If state_vintilation rises again during ramp-down, the ramp reverses at the next step and does not pass through OFF.
- ramp_busy = (fsm_state==RAMP).
- fan_on is high in RAMP and RUN and low only in OFF.

Test Plan:
- Reset: hold rst=0 for 3 cycles with state_vintilation=1, counter=9 -> all outputs 0 and fsm_state=OFF. Release, and at the first edge fsm_state=RAMP, fan_on=1.
- Ramp up: counter=10, state_vintilation=1 from OFF at edge k -> speed=1 at k+8, speed=10 at k+80, fsm_state=RUN at k+81. Over 16 cycles in RUN, fan_pwm is high for exactly 10.
- Min duty: counter=1, state_vintilation=1 -> speed settles at 4 (MIN_DUTY), RUN. Set counter=0 -> speed stays at 4.
- Minimum on-time: pulse state_vintilation=1 for 1 cycle with counter=0 -> fan_on high for at least 32 cycles. Speed rises to 4, ramps down to 0 after the timer expires, then fsm_state=OFF with fan_on=0.
- Reversal: in RUN at speed 12, drop state_vintilation (timer expired) -> speed decrements every 8 cycles. Reassert at speed 7 with counter=9 -> next step gives 8, then 9, then RUN, with no OFF visit.
- Reset mid-ramp: rst=0 while speed=6 in RAMP -> next edge speed=0, fan_on=0, fan_pwm=0, fsm_state=OFF.
